// File: rtl/memory_access.sv
// memory_access: RV32IM memory stage with busywait handshake, load/store lane handling and MEM/WB register
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUD,
    input  logic [31:0] ALU_result,
    input  logic [31:0] data2,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        memory_read_enable,
    input  logic        memory_write_enable,
    input  logic        regwrite_enable,
    input  logic        mux3_select,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait,
    output logic        stall,
    output logic        misaligned,
    output logic        mem_error,
    output logic [31:0] ALUD_out,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        regwrite_enable_out,
    output logic        mux3_select_out
);
    localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t      state;
    logic [7:0]  count;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [4:0]  op_rd;
    logic [31:0] op_alud;
    logic        op_regwrite, op_mux3;
    logic        mem_op, illegal, load_ok, store_ok, align_ok;
    logic [31:0] wdata, rdata_ext;
    logic [3:0]  be;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    always_comb begin
        mem_op    = memory_read_enable | memory_write_enable;
        load_ok   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
        align_ok  = funct3[1:0] == 2'b01 ? !ALU_result[0] :
                    funct3[1:0] == 2'b10 ? ALU_result[1:0] == 2'b00 : 1'b1;
        illegal   = (memory_read_enable & memory_write_enable) | (memory_read_enable & !load_ok) |
                    (memory_write_enable & !store_ok) | !align_ok;
        wdata     = funct3[1:0] == 2'b00 ? {4{data2[7:0]}} :
                    funct3[1:0] == 2'b01 ? {2{data2[15:0]}} : data2;
        be        = funct3[1:0] == 2'b00 ? 4'b0001 << ALU_result[1:0] :
                    funct3[1:0] == 2'b01 ? (ALU_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        stall     = state == IDLE ? mem_op & !illegal : mem_busywait & (count < TMAX);
        byte_sel  = mem_readdata[{op_off, 3'b000} +: 8];
        half_sel  = op_off[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        rdata_ext = op_funct3 == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                    op_funct3 == 3'b100 ? {24'd0, byte_sel} :
                    op_funct3 == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                    op_funct3 == 3'b101 ? {16'd0, half_sel} : mem_readdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            count               <= '0;
            mem_read            <= 1'b0;
            mem_write           <= 1'b0;
            mem_address         <= '0;
            mem_writedata       <= '0;
            mem_byteenable      <= '0;
            misaligned          <= 1'b0;
            mem_error           <= 1'b0;
            ALUD_out            <= '0;
            load_data           <= '0;
            rd_out              <= '0;
            regwrite_enable_out <= 1'b0;
            mux3_select_out     <= 1'b0;
            op_funct3           <= '0;
            op_off              <= '0;
            op_rd               <= '0;
            op_alud             <= '0;
            op_regwrite         <= 1'b0;
            op_mux3             <= 1'b0;
        end else begin
            misaligned          <= 1'b0;
            mem_error           <= 1'b0;
            regwrite_enable_out <= 1'b0;
            if (state == IDLE) begin
                if (!mem_op) begin
                    ALUD_out            <= ALUD;
                    rd_out              <= rd;
                    regwrite_enable_out <= regwrite_enable;
                    mux3_select_out     <= mux3_select;
                    load_data           <= '0;
                end else if (illegal) begin
                    misaligned <= 1'b1;
                end else begin
                    mem_read       <= memory_read_enable;
                    mem_write      <= memory_write_enable;
                    mem_address    <= {ALU_result[31:2], 2'b00};
                    mem_writedata  <= wdata;
                    mem_byteenable <= memory_read_enable ? 4'b1111 : be;
                    op_funct3      <= funct3;
                    op_off         <= ALU_result[1:0];
                    op_rd          <= rd;
                    op_alud        <= ALUD;
                    op_regwrite    <= regwrite_enable;
                    op_mux3        <= mux3_select;
                    count          <= '0;
                    state          <= ACCESS;
                end
            end else if (!mem_busywait) begin
                ALUD_out            <= op_alud;
                rd_out              <= op_rd;
                regwrite_enable_out <= op_regwrite;
                mux3_select_out     <= op_mux3;
                load_data           <= mem_read ? rdata_ext : '0;
                mem_read            <= 1'b0;
                mem_write           <= 1'b0;
                state               <= IDLE;
            end else if (count >= TMAX) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                mem_error <= 1'b1;
                state     <= IDLE;
            end else begin
                count <= count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed scoreboard bench for the memory-access stage
module tb_memory_access;
    logic        clk = 0, reset = 1;
    logic [31:0] ALUD = 0, ALU_result = 0, data2 = 0, mem_readdata = 0;
    logic [2:0]  funct3 = 0;
    logic [4:0]  rd = 0;
    logic        memory_read_enable = 0, memory_write_enable = 0, regwrite_enable = 0, mux3_select = 0;
    logic        mem_busywait = 0;
    logic        mem_read, mem_write, stall, misaligned, mem_error, regwrite_enable_out, mux3_select_out;
    logic [31:0] mem_address, mem_writedata, ALUD_out, load_data;
    logic [3:0]  mem_byteenable;
    logic [4:0]  rd_out;
    int checks = 0, failures = 0;
    typedef struct {logic [31:0] load; logic [31:0] alud; logic [4:0] rd; logic rw; logic mux3;} exp_t;
    exp_t q[$];

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ALUD(ALUD), .ALU_result(ALU_result), .data2(data2),
        .funct3(funct3), .rd(rd), .memory_read_enable(memory_read_enable),
        .memory_write_enable(memory_write_enable), .regwrite_enable(regwrite_enable),
        .mux3_select(mux3_select), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait), .stall(stall),
        .misaligned(misaligned), .mem_error(mem_error), .ALUD_out(ALUD_out), .load_data(load_data),
        .rd_out(rd_out), .regwrite_enable_out(regwrite_enable_out), .mux3_select_out(mux3_select_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_check(string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, ALUD_out);
        end else begin
            e = q.pop_front();
            chk({tag, "_load"}, load_data, e.load);
            chk({tag, "_alud"}, ALUD_out, e.alud);
            chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
            chk({tag, "_rw"}, {31'd0, regwrite_enable_out}, {31'd0, e.rw});
            chk({tag, "_mux3"}, {31'd0, mux3_select_out}, {31'd0, e.mux3});
        end
    endtask

    task automatic idle_in(logic [31:0] alud, logic [4:0] rdi);
        memory_read_enable = 0; memory_write_enable = 0; regwrite_enable = 1; mux3_select = 0;
        ALUD = alud; rd = rdi; mem_busywait = 0;
    endtask

    task automatic do_mem(string tag, logic r, logic w, logic [2:0] f3, logic [31:0] addr,
                          logic [31:0] d2, logic [4:0] rdi, logic [31:0] alud, int waits,
                          logic [31:0] rdata, logic [31:0] exp_addr, logic [31:0] exp_wd,
                          logic [3:0] exp_be, logic [31:0] exp_load);
        int st = 0;
        memory_read_enable = r; memory_write_enable = w; funct3 = f3; ALU_result = addr;
        data2 = d2; rd = rdi; ALUD = alud; regwrite_enable = r; mux3_select = r;
        mem_busywait = waits > 0; mem_readdata = 32'hFFFF_FFFF;
        q.push_back('{exp_load, alud, rdi, r, r});
        #1 if (stall) st++;
        step();
        chk({tag, "_addr"}, mem_address, exp_addr);
        chk({tag, "_be"}, {28'd0, mem_byteenable}, {28'd0, exp_be});
        chk({tag, "_rdreq"}, {31'd0, mem_read}, {31'd0, r});
        chk({tag, "_wrreq"}, {31'd0, mem_write}, {31'd0, w});
        chk({tag, "_bubble"}, {31'd0, regwrite_enable_out}, 32'd0);
        if (w) chk({tag, "_wdata"}, mem_writedata, exp_wd);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                mem_busywait = 0;
                mem_readdata = rdata;
            end
            #1 if (stall) st++;
            step();
        end
        chk({tag, "_rd_drop"}, {31'd0, mem_read}, 32'd0);
        chk({tag, "_wr_drop"}, {31'd0, mem_write}, 32'd0);
        chk({tag, "_stall_cycles"}, st, waits + 1);
        wb_check(tag);
        idle_in(32'h0, 5'd0);
    endtask

    initial begin
        ALUD = 32'hDEAD_BEEF; rd = 5'd5; regwrite_enable = 1;
        step(); step();
        chk("rst_alud", ALUD_out, 0);
        chk("rst_rw", {31'd0, regwrite_enable_out}, 0);
        chk("rst_req", {30'd0, mem_read, mem_write}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_pulses", {30'd0, misaligned, mem_error}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wd", mem_writedata, 0);
        chk("rst_be", {28'd0, mem_byteenable}, 0);
        chk("rst_load", load_data, 0);
        reset = 0;
        q.push_back('{32'h0, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0});
        step();
        wb_check("nonmem");

        do_mem("sb", 0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd0, 32'h11, 0, 0,
               32'h1000, 32'hA5A5_A5A5, 4'b1000, 32'h0);
        do_mem("sh", 0, 1, 3'b001, 32'h1002, 32'h0000_CAFE, 5'd0, 32'h12, 1, 0,
               32'h1000, 32'hCAFE_CAFE, 4'b1100, 32'h0);
        do_mem("sw", 0, 1, 3'b010, 32'h3004, 32'h1234_5678, 5'd0, 32'h13, 0, 0,
               32'h3004, 32'h1234_5678, 4'b1111, 32'h0);
        do_mem("lb", 1, 0, 3'b000, 32'h2001, 0, 5'd7, 32'h2001, 3, 32'h0000_8000,
               32'h2000, 0, 4'b1111, 32'hFFFF_FF80);
        do_mem("lbu", 1, 0, 3'b100, 32'h2003, 0, 5'd8, 32'h2003, 0, 32'h9A00_0000,
               32'h2000, 0, 4'b1111, 32'h0000_009A);
        do_mem("lhu", 1, 0, 3'b101, 32'h2002, 0, 5'd9, 32'h2002, 0, 32'hBEEF_1234,
               32'h2000, 0, 4'b1111, 32'h0000_BEEF);
        do_mem("lh", 1, 0, 3'b001, 32'h2002, 0, 5'd10, 32'h2002, 2, 32'hBEEF_1234,
               32'h2000, 0, 4'b1111, 32'hFFFF_BEEF);
        do_mem("lw", 1, 0, 3'b010, 32'h3008, 0, 5'd11, 32'h3008, 1, 32'h0BAD_F00D,
               32'h3008, 0, 4'b1111, 32'h0BAD_F00D);

        memory_read_enable = 1; funct3 = 3'b010; ALU_result = 32'h3002; rd = 5'd12;
        #1 chk("mis_stall", {31'd0, stall}, 0);
        step();
        chk("mis_pulse", {31'd0, misaligned}, 1);
        chk("mis_noreq", {31'd0, mem_read}, 0);
        chk("mis_bubble", {31'd0, regwrite_enable_out}, 0);
        idle_in(32'h55, 5'd3);
        step();
        chk("mis_pulse_end", {31'd0, misaligned}, 0);

        memory_read_enable = 1; funct3 = 3'b010; ALU_result = 32'h4000; mem_busywait = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", {31'd0, stall}, 1);
            chk("to_noerr", {31'd0, mem_error}, 0);
            step();
        end
        chk("to_abort_stall", {31'd0, stall}, 0);
        chk("to_abort_req", {31'd0, mem_read}, 1);
        step();
        chk("to_err", {31'd0, mem_error}, 1);
        chk("to_drop", {31'd0, mem_read}, 0);
        chk("to_bubble", {31'd0, regwrite_enable_out}, 0);
        idle_in(32'h0, 5'd0);
        step();
        chk("to_err_end", {31'd0, mem_error}, 0);

        memory_read_enable = 1; funct3 = 3'b010; ALU_result = 32'h5000; mem_busywait = 1;
        step(); step();
        chk("mid_req", {31'd0, mem_read}, 1);
        reset = 1;
        step();
        chk("mid_drop", {31'd0, mem_read}, 0);
        chk("mid_pulses", {30'd0, misaligned, mem_error}, 0);
        reset = 0;
        idle_in(32'h77, 5'd4);
        step();
        chk("mid_after_pulses", {30'd0, misaligned, mem_error}, 0);
        chk("mid_after_req", {31'd0, mem_read}, 0);
        chk("mid_after_alud", ALUD_out, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
